// File: rtl/digitube_pkg.sv
// rtl/digitube_pkg.sv - shared types and constants for the scanning-tube controller
// Contents: DIGI_BLANK (all anodes off, DP and segments released),
//           SEG_TABLE (hex nibble to active-low {CG..CA}, CA = bit 0),
//           digit_idx_t (2-bit digit index).
package digitube_pkg;

    typedef logic [1:0] digit_idx_t;

    localparam logic [11:0] DIGI_BLANK = 12'h0FF;

    // Entry n is the active-low segment pattern for hex digit n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

endpackage

// File: rtl/hex7seg.sv
// rtl/hex7seg.sv - combinational hex nibble to active-low 7-segment decode
// Ports: nibble [3:0] in  - hex value 0..F
//        seg    [6:0] out - {CG..CA}, active-low
module hex7seg
    import digitube_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/digitube_ctrl.sv
// rtl/digitube_ctrl.sv - four-digit multiplexed 7-segment scan controller
// Optional feature: define DIGITUBE_LZB_EN for leading-zero blanking.
// Ports: clk        in      - single clock, rising edge
//        reset      in      - asynchronous, active-low
//        en         in      - scan enable; 0 freezes scan and blanks output
//        load       in      - one-cycle strobe capturing data_in/dp_in
//        data_in    in [15:0] - four hex nibbles, [15:12] -> digit 3
//        dp_in      in [3:0]  - per-digit decimal point request, active-high
//        digi_out   out [11:0] - {AN3..AN0, DP, CG..CA}; AN active-high,
//                                DP and segments active-low
//        frame_done out      - one-cycle pulse after each digit 3->0 wrap
module digitube_ctrl
    import digitube_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] data_in,
    input  logic [3:0]  dp_in,
    output logic [11:0] digi_out,
    output logic        frame_done
);

    // 20 bits covers the largest legal divider (2^20 - 1 terminal count).
    localparam logic [19:0] CNT_MAX = 20'(SCAN_DIV - 1);

    logic [19:0] cnt;
    digit_idx_t  idx;
    logic [15:0] pend_data;
    logic [3:0]  pend_dp;
    logic [15:0] disp_data;
    logic [3:0]  disp_dp;

    logic        div_wrap;
    logic        frame_wrap;
    logic [3:0]  cur_nibble;
    logic [6:0]  dec_seg;
    logic [6:0]  cur_seg;
    logic        lz_blank;
    logic [11:0] digi_next;

    assign div_wrap   = en && (cnt == CNT_MAX);
    assign frame_wrap = div_wrap && (idx == 2'd3);

    assign cur_nibble = disp_data[{idx, 2'b00} +: 4];

    hex7seg u_hex7seg (
        .nibble (cur_nibble),
        .seg    (dec_seg)
    );

`ifdef DIGITUBE_LZB_EN
    // Digit i is a leading zero when it and every nibble above it are zero;
    // digit 0 always shows so a zero value still reads "0".
    assign lz_blank = (idx != 2'd0) && ((disp_data >> {idx, 2'b00}) == 16'h0000);
`else
    assign lz_blank = 1'b0;
`endif

    assign cur_seg   = lz_blank ? 7'h7F : dec_seg;
    assign digi_next = {4'b0001 << idx, ~disp_dp[idx], cur_seg};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt        <= '0;
            idx        <= '0;
            pend_data  <= '0;
            pend_dp    <= '0;
            disp_data  <= '0;
            disp_dp    <= '0;
            digi_out   <= DIGI_BLANK;
            frame_done <= 1'b0;
        end else begin
            if (en) begin
                cnt <= div_wrap ? '0 : cnt + 20'd1;
            end
            if (div_wrap) begin
                idx <= idx + 2'd1;
            end
            if (load) begin
                pend_data <= data_in;
                pend_dp   <= dp_in;
            end
            // Display only changes at a frame boundary; a load landing on
            // that same edge bypasses pending so it is not a frame late.
            if (frame_wrap) begin
                disp_data <= load ? data_in : pend_data;
                disp_dp   <= load ? dp_in   : pend_dp;
            end
            frame_done <= frame_wrap;
            digi_out   <= en ? digi_next : DIGI_BLANK;
        end
    end

endmodule

// File: tb/tb_digitube_ctrl.sv
// tb/tb_digitube_ctrl.sv - self-checking bench for digitube_ctrl (SCAN_DIV=4)
module tb_digitube_ctrl;

    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [15:0] data_in = '0;
    logic [3:0]  dp_in = '0;
    logic [11:0] digi_out;
    logic        frame_done;

    int n_total = 0;
    int n_bad = 0;

    digitube_ctrl #(.SCAN_DIV(SD)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .load       (load),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .digi_out   (digi_out),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Reference model: the scan position follows from the number of enabled
    // clock edges since reset; the frame boundary is the last edge of each
    // 4*SD-edge frame.
    logic [6:0] segs [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    int unsigned m_t;
    logic [15:0] m_pend, m_disp;
    logic [3:0]  m_pdp, m_ddp;

    function automatic logic [11:0] ref_digit(int i, logic [15:0] d, logic [3:0] dp);
        logic [6:0] s;
        s = segs[(d >> (4 * i)) & 16'hF];
`ifdef DIGITUBE_LZB_EN
        if (i > 0 && (d >> (4 * i)) == 16'h0) s = 7'h7F;
`endif
        return {4'(1 << i), ~dp[i], s};
    endfunction

    task automatic model_reset();
        m_t = 0;
        m_pend = '0;
        m_disp = '0;
        m_pdp = '0;
        m_ddp = '0;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: update the model from the inputs seen at the edge, then
    // compare both outputs shortly after the edge.
    task automatic step();
        logic [11:0] e_digi;
        logic        e_fd;
        @(posedge clk);
        e_fd = 1'b0;
        e_digi = 12'h0FF;
        if (en) begin
            e_digi = ref_digit(int'((m_t / SD) % 4), m_disp, m_ddp);
            e_fd = ((m_t % (4 * SD)) == (4 * SD - 1));
            m_t++;
        end
        if (e_fd) begin
            m_disp = load ? data_in : m_pend;
            m_ddp  = load ? dp_in : m_pdp;
        end
        if (load) begin
            m_pend = data_in;
            m_pdp  = dp_in;
        end
        #1;
        chk("model_digi_out", 32'(digi_out), 32'(e_digi));
        chk("model_frame_done", 32'(frame_done), 32'(e_fd));
    endtask

    task automatic steps(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_load(logic [15:0] d, logic [3:0] p);
        load = 1'b1;
        data_in = d;
        dp_in = p;
        step();
        load = 1'b0;
    endtask

    task automatic wait_fd();
        int k;
        for (k = 0; k < 64; k++) begin
            step();
            if (frame_done) break;
        end
        chk("wait_frame_done_in_budget", 32'(k < 64), 32'd1);
    endtask

    typedef struct {
        logic [15:0]      data;
        logic [3:0]       dp;
        logic [3:0][11:0] exp;   // exp[k] = digi_out while digit k is driven
    } vec_t;

    vec_t vecs [6];
    int   cnt2;

    initial begin
        vecs[0].data = 16'h1234; vecs[0].dp = 4'b0000;
        vecs[0].exp  = {{4'b1000, 1'b1, 7'b1111001}, {4'b0100, 1'b1, 7'b0100100},
                        {4'b0010, 1'b1, 7'b0110000}, {4'b0001, 1'b1, 7'b0011001}};
        vecs[1].data = 16'hABCD; vecs[1].dp = 4'b0101;
        vecs[1].exp  = {{4'b1000, 1'b1, 7'b0001000}, {4'b0100, 1'b0, 7'b0000011},
                        {4'b0010, 1'b1, 7'b1000110}, {4'b0001, 1'b0, 7'b0100001}};
        vecs[2].data = 16'h0050; vecs[2].dp = 4'b1000;
`ifdef DIGITUBE_LZB_EN
        vecs[2].exp  = {{4'b1000, 1'b0, 7'b1111111}, {4'b0100, 1'b1, 7'b1111111},
                        {4'b0010, 1'b1, 7'b0010010}, {4'b0001, 1'b1, 7'b1000000}};
`else
        vecs[2].exp  = {{4'b1000, 1'b0, 7'b1000000}, {4'b0100, 1'b1, 7'b1000000},
                        {4'b0010, 1'b1, 7'b0010010}, {4'b0001, 1'b1, 7'b1000000}};
`endif
        vecs[3].data = 16'h8F06; vecs[3].dp = 4'b0010;
        vecs[3].exp  = {{4'b1000, 1'b1, 7'b0000000}, {4'b0100, 1'b1, 7'b0001110},
                        {4'b0010, 1'b0, 7'b1000000}, {4'b0001, 1'b1, 7'b0000010}};
        vecs[4].data = 16'h0007; vecs[4].dp = 4'b0000;
`ifdef DIGITUBE_LZB_EN
        vecs[4].exp  = {{4'b1000, 1'b1, 7'b1111111}, {4'b0100, 1'b1, 7'b1111111},
                        {4'b0010, 1'b1, 7'b1111111}, {4'b0001, 1'b1, 7'b1111000}};
`else
        vecs[4].exp  = {{4'b1000, 1'b1, 7'b1000000}, {4'b0100, 1'b1, 7'b1000000},
                        {4'b0010, 1'b1, 7'b1000000}, {4'b0001, 1'b1, 7'b1111000}};
`endif
        vecs[5].data = 16'h0000; vecs[5].dp = 4'b1111;
`ifdef DIGITUBE_LZB_EN
        vecs[5].exp  = {{4'b1000, 1'b0, 7'b1111111}, {4'b0100, 1'b0, 7'b1111111},
                        {4'b0010, 1'b0, 7'b1111111}, {4'b0001, 1'b0, 7'b1000000}};
`else
        vecs[5].exp  = {{4'b1000, 1'b0, 7'b1000000}, {4'b0100, 1'b0, 7'b1000000},
                        {4'b0010, 1'b0, 7'b1000000}, {4'b0001, 1'b0, 7'b1000000}};
`endif

        // Reset state, then first enabled edge shows digit 0 = "0".
        #1 reset = 1'b0;
        model_reset();
        #1;
        chk("reset_digi_out", 32'(digi_out), 32'h0FF);
        chk("reset_frame_done", 32'(frame_done), 32'd0);
        en = 1'b1;
        #10 reset = 1'b1;
        step();
        chk("first_digit0_zero", 32'(digi_out), 32'({4'b0001, 1'b1, 7'b1000000}));

        // Table: load a value, then check each digit of the next frame and
        // the 16-cycle frame_done spacing.
        for (int v = 0; v < 6; v++) begin
            steps(v + 2);
            do_load(vecs[v].data, vecs[v].dp);
            wait_fd();
            for (int k = 0; k < 4; k++) begin
                steps(k == 0 ? 1 : SD);
                chk($sformatf("vec%0d_digit%0d", v, k), 32'(digi_out), 32'(vecs[v].exp[k]));
            end
            steps(3);
            chk($sformatf("vec%0d_frame_period", v), 32'(frame_done), 32'd1);
        end

        // Mid-frame load keeps the current frame intact.
        do_load(16'h1234, 4'b0000);
        wait_fd();
        steps(5);
        do_load(16'hABCD, 4'b0000);
        steps(3);
        chk("midload_old_digit2", 32'(digi_out), 32'({4'b0100, 1'b1, 7'b0100100}));
        steps(4);
        chk("midload_old_digit3", 32'(digi_out), 32'({4'b1000, 1'b1, 7'b1111001}));
        steps(3);
        chk("midload_frame_done", 32'(frame_done), 32'd1);
        step();
        chk("midload_new_digit0", 32'(digi_out), 32'({4'b0001, 1'b1, 7'b0100001}));

        // Load on the wrap edge goes straight to the display.
        wait_fd();
        steps(15);
        load = 1'b1; data_in = 16'h5A5A; dp_in = 4'b0001;
        step();
        load = 1'b0;
        chk("wrapload_frame_done", 32'(frame_done), 32'd1);
        step();
        chk("wrapload_digit0", 32'(digi_out), 32'({4'b0001, 1'b0, 7'b0001000}));

        // Pause mid digit 2; it finishes its remaining two cycles afterwards.
        wait_fd();
        steps(9);
        chk("pause_at_digit2", 32'(digi_out[11:8]), 32'(4'b0100));
        step();
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("pause_blank", 32'(digi_out), 32'h0FF);
            chk("pause_no_frame_done", 32'(frame_done), 32'd0);
        end
        en = 1'b1;
        cnt2 = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (digi_out[11:8] != 4'b0100) break;
            cnt2++;
        end
        chk("resume_digit2_remaining", 32'(cnt2), 32'd2);
        chk("resume_next_digit3", 32'(digi_out[11:8]), 32'(4'b1000));

        // Asynchronous reset mid-frame discards a pending load.
        steps(2);
        do_load(16'h7777, 4'b1111);
        #3 reset = 1'b0;
        model_reset();
        #1;
        chk("async_reset_digi_out", 32'(digi_out), 32'h0FF);
        chk("async_reset_frame_done", 32'(frame_done), 32'd0);
        #7 reset = 1'b1;
        step();
        chk("after_reset_digit0", 32'(digi_out), 32'({4'b0001, 1'b1, 7'b1000000}));
        wait_fd();
        step();
        chk("pending_discarded", 32'(digi_out), 32'({4'b0001, 1'b1, 7'b1000000}));

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            en = ($urandom_range(0, 7) != 0);
            load = ($urandom_range(0, 5) == 0);
            data_in = 16'($urandom);
            dp_in = 4'($urandom);
            step();
        end
        load = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
